// File: rtl/rec_play_ctrl_if.sv
// Signal bundle between the record/playback controller and the key, codec,
// recorder and DSP blocks. The controller uses the master modport, its peers the slave modport.
interface rec_play_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int SLOTS  = 4
);
  localparam int SLOT_W = $clog2(SLOTS);

  logic              i_key_rec;
  logic              i_key_play;
  logic              i_key_stop;
  logic [SLOT_W-1:0] i_slot_sel;
  logic              i_i2c_fin;
  logic [ADDR_W-1:0] i_rec_addr;
  logic              i_rec_fin;
  logic              i_play_fin;

  logic              o_i2c_start;
  logic              o_rec_start;
  logic              o_rec_pause;
  logic              o_rec_stop;
  logic              o_dsp_start;
  logic              o_dsp_pause;
  logic              o_dsp_stop;
  logic [ADDR_W-1:0] o_base_addr;
  logic [ADDR_W-1:0] o_stop_addr;
  logic [SLOT_W-1:0] o_active_slot;
  logic [SLOTS-1:0]  o_slot_valid;
  logic              o_rec_sel;
  logic              o_sram_we_n;
  logic [2:0]        o_state;

  modport master (
    input  i_key_rec, i_key_play, i_key_stop, i_slot_sel, i_i2c_fin,
           i_rec_addr, i_rec_fin, i_play_fin,
    output o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop,
           o_dsp_start, o_dsp_pause, o_dsp_stop, o_base_addr, o_stop_addr,
           o_active_slot, o_slot_valid, o_rec_sel, o_sram_we_n, o_state
  );

  modport slave (
    output i_key_rec, i_key_play, i_key_stop, i_slot_sel, i_i2c_fin,
           i_rec_addr, i_rec_fin, i_play_fin,
    input  o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop,
           o_dsp_start, o_dsp_pause, o_dsp_stop, o_base_addr, o_stop_addr,
           o_active_slot, o_slot_valid, o_rec_sel, o_sram_we_n, o_state
  );
endinterface

// File: rtl/rec_play_ctrl.sv
// Multi-slot record/playback controller: codec init, key arbitration, per-slot end address/valid.
// Define REC_PLAY_LOOP_EN to restart playback of the active slot when the DSP reaches the stop address.
module rec_play_ctrl #(
  parameter int ADDR_W = 20,
  parameter int SLOTS  = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  rec_play_ctrl_if.master bus
);
  localparam int SLOT_W     = $clog2(SLOTS);
  localparam int SLOT_DEPTH = (2 ** ADDR_W) / SLOTS;
  localparam logic [ADDR_W-1:0] LAST_OFFSET = ADDR_W'(SLOT_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_I2C        = 3'd1,
    S_RECD       = 3'd2,
    S_RECD_PAUSE = 3'd3,
    S_PLAY       = 3'd4,
    S_PLAY_PAUSE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              key_rec_q, key_play_q, key_stop_q;
  logic [SLOT_W-1:0] active_slot_q, active_slot_d;
  logic [SLOTS-1:0]  slot_valid_q, slot_valid_d;
  logic [ADDR_W-1:0] end_addr_q [SLOTS];
  logic [ADDR_W-1:0] end_addr_d [SLOTS];
  logic              rec_start_q, rec_start_d;
  logic              rec_pause_q, rec_pause_d;
  logic              rec_stop_q, rec_stop_d;
  logic              dsp_start_q, dsp_start_d;
  logic              dsp_pause_q, dsp_pause_d;
  logic              dsp_stop_q, dsp_stop_d;
`ifdef REC_PLAY_LOOP_EN
  logic              restart_q, restart_d;
`endif

  logic              rise_rec, rise_play, rise_stop;
  logic [ADDR_W-1:0] base_addr;
  logic              rec_done;

  assign rise_rec  = bus.i_key_rec  & ~key_rec_q;
  assign rise_play = bus.i_key_play & ~key_play_q;
  assign rise_stop = bus.i_key_stop & ~key_stop_q;

  assign base_addr = {active_slot_q, {(ADDR_W-SLOT_W){1'b0}}};
  assign rec_done  = rise_stop | bus.i_rec_fin | (bus.i_rec_addr == (base_addr | LAST_OFFSET));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_I2C;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      key_rec_q     <= 1'b0;
      key_play_q    <= 1'b0;
      key_stop_q    <= 1'b0;
      active_slot_q <= '0;
      slot_valid_q  <= '0;
      end_addr_q    <= '{default: '0};
      rec_start_q   <= 1'b0;
      rec_pause_q   <= 1'b0;
      rec_stop_q    <= 1'b0;
      dsp_start_q   <= 1'b0;
      dsp_pause_q   <= 1'b0;
      dsp_stop_q    <= 1'b0;
`ifdef REC_PLAY_LOOP_EN
      restart_q     <= 1'b0;
`endif
    end else begin
      key_rec_q     <= bus.i_key_rec;
      key_play_q    <= bus.i_key_play;
      key_stop_q    <= bus.i_key_stop;
      active_slot_q <= active_slot_d;
      slot_valid_q  <= slot_valid_d;
      end_addr_q    <= end_addr_d;
      rec_start_q   <= rec_start_d;
      rec_pause_q   <= rec_pause_d;
      rec_stop_q    <= rec_stop_d;
      dsp_start_q   <= dsp_start_d;
      dsp_pause_q   <= dsp_pause_d;
      dsp_stop_q    <= dsp_stop_d;
`ifdef REC_PLAY_LOOP_EN
      restart_q     <= restart_d;
`endif
    end
  end

  // A stop key in idle is consumed without effect so it still outranks a simultaneous rec/play.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_I2C:  if (bus.i_i2c_fin) state_d = S_IDLE;
      S_IDLE: begin
        if (rise_stop)                                  state_d = S_IDLE;
        else if (rise_rec)                              state_d = S_RECD;
        else if (rise_play && slot_valid_q[bus.i_slot_sel]) state_d = S_PLAY;
      end
      S_RECD: begin
        if (rec_done)      state_d = S_IDLE;
        else if (rise_rec) state_d = S_RECD_PAUSE;
      end
      S_RECD_PAUSE: begin
        if (rise_stop)     state_d = S_IDLE;
        else if (rise_rec) state_d = S_RECD;
      end
      S_PLAY: begin
        if (rise_stop) state_d = S_IDLE;
`ifdef REC_PLAY_LOOP_EN
        else if (restart_q || bus.i_play_fin) state_d = S_PLAY;
`else
        else if (bus.i_play_fin) state_d = S_IDLE;
`endif
        else if (rise_play) state_d = S_PLAY_PAUSE;
      end
      S_PLAY_PAUSE: begin
        if (rise_stop)      state_d = S_IDLE;
        else if (rise_play) state_d = S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    active_slot_d = active_slot_q;
    slot_valid_d  = slot_valid_q;
    end_addr_d    = end_addr_q;
    rec_start_d   = 1'b0;
    rec_pause_d   = 1'b0;
    rec_stop_d    = 1'b0;
    dsp_start_d   = 1'b0;
    dsp_pause_d   = 1'b0;
    dsp_stop_d    = 1'b0;
`ifdef REC_PLAY_LOOP_EN
    restart_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rise_stop && rise_rec) begin
          active_slot_d                = bus.i_slot_sel;
          slot_valid_d[bus.i_slot_sel] = 1'b0;
          rec_start_d                  = 1'b1;
        end else if (!rise_stop && rise_play && slot_valid_q[bus.i_slot_sel]) begin
          active_slot_d = bus.i_slot_sel;
          dsp_start_d   = 1'b1;
        end
      end
      S_RECD, S_RECD_PAUSE: begin
        if ((state_q == S_RECD) ? rec_done : rise_stop) begin
          end_addr_d[active_slot_q]   = bus.i_rec_addr;
          slot_valid_d[active_slot_q] = (bus.i_rec_addr != base_addr);
          rec_stop_d                  = 1'b1;
        end else if (rise_rec) begin
          rec_pause_d = (state_q == S_RECD);
          rec_start_d = (state_q == S_RECD_PAUSE);
        end
      end
      S_PLAY: begin
        if (rise_stop) dsp_stop_d = 1'b1;
`ifdef REC_PLAY_LOOP_EN
        else if (restart_q) dsp_start_d = 1'b1;
        else if (bus.i_play_fin) begin
          dsp_stop_d = 1'b1;
          restart_d  = 1'b1;
        end
`else
        else if (bus.i_play_fin) dsp_stop_d = 1'b1;
`endif
        else if (rise_play) dsp_pause_d = 1'b1;
      end
      S_PLAY_PAUSE: begin
        if (rise_stop)      dsp_stop_d  = 1'b1;
        else if (rise_play) dsp_start_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.o_i2c_start   = (state_q == S_I2C);
  assign bus.o_rec_start   = rec_start_q;
  assign bus.o_rec_pause   = rec_pause_q;
  assign bus.o_rec_stop    = rec_stop_q;
  assign bus.o_dsp_start   = dsp_start_q;
  assign bus.o_dsp_pause   = dsp_pause_q;
  assign bus.o_dsp_stop    = dsp_stop_q;
  assign bus.o_base_addr   = base_addr;
  assign bus.o_stop_addr   = end_addr_q[active_slot_q];
  assign bus.o_active_slot = active_slot_q;
  assign bus.o_slot_valid  = slot_valid_q;
  assign bus.o_rec_sel     = (state_q == S_RECD);
  assign bus.o_sram_we_n   = ~(state_q == S_RECD);
  assign bus.o_state       = state_q;
endmodule

// File: tb/tb_rec_play_ctrl.sv
// Directed self-checking bench for rec_play_ctrl; the play-finish checks follow REC_PLAY_LOOP_EN.
module tb_rec_play_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  rec_play_ctrl_if #(.ADDR_W(20), .SLOTS(4)) bus ();

  rec_play_ctrl #(.ADDR_W(20), .SLOTS(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.i_key_rec  = 1'b0;
    bus.i_key_play = 1'b0;
    bus.i_key_stop = 1'b0;
    bus.i_slot_sel = 2'd0;
    bus.i_i2c_fin  = 1'b0;
    bus.i_rec_addr = 20'h0;
    bus.i_rec_fin  = 1'b0;
    bus.i_play_fin = 1'b0;

    step();
    check("rst_state", 32'(bus.o_state), 32'd1);
    check("rst_i2c_start", 32'(bus.o_i2c_start), 32'd1);
    check("rst_pulses", 32'({bus.o_rec_start, bus.o_rec_pause, bus.o_rec_stop,
                             bus.o_dsp_start, bus.o_dsp_pause, bus.o_dsp_stop}), 32'd0);
    check("rst_valid", 32'(bus.o_slot_valid), 32'd0);
    check("rst_active", 32'(bus.o_active_slot), 32'd0);
    check("rst_stop_addr", 32'(bus.o_stop_addr), 32'd0);
    check("rst_rec_sel", 32'(bus.o_rec_sel), 32'd0);
    check("rst_we_n", 32'(bus.o_sram_we_n), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (i == 3) bus.i_key_rec = 1'b1;
      if (i == 5) bus.i_key_play = 1'b1;
      if (i == 7) begin
        bus.i_key_rec  = 1'b0;
        bus.i_key_play = 1'b0;
      end
      step();
      check("i2c_state", 32'(bus.o_state), 32'd1);
      check("i2c_start_held", 32'(bus.o_i2c_start), 32'd1);
      check("i2c_no_pulse", 32'({bus.o_rec_start, bus.o_dsp_start}), 32'd0);
    end
    bus.i_i2c_fin = 1'b1;
    step();
    check("i2c_done_state", 32'(bus.o_state), 32'd0);
    check("i2c_done_start", 32'(bus.o_i2c_start), 32'd0);
    bus.i_i2c_fin = 1'b0;

    bus.i_slot_sel = 2'd2;
    bus.i_rec_addr = 20'h80000;
    bus.i_key_rec  = 1'b1;
    step();
    check("s2_rec_start", 32'(bus.o_rec_start), 32'd1);
    check("s2_state_recd", 32'(bus.o_state), 32'd2);
    check("s2_rec_sel", 32'(bus.o_rec_sel), 32'd1);
    check("s2_we_n", 32'(bus.o_sram_we_n), 32'd0);
    check("s2_active", 32'(bus.o_active_slot), 32'd2);
    check("s2_base", 32'(bus.o_base_addr), 32'h80000);
    step();
    check("s2_held_no_pulse", 32'(bus.o_rec_start), 32'd0);
    bus.i_key_rec  = 1'b0;
    bus.i_rec_addr = 20'h80100;
    bus.i_key_stop = 1'b1;
    step();
    check("s2_rec_stop", 32'(bus.o_rec_stop), 32'd1);
    check("s2_state_idle", 32'(bus.o_state), 32'd0);
    check("s2_valid", 32'(bus.o_slot_valid), 32'b0100);
    check("s2_stop_addr", 32'(bus.o_stop_addr), 32'h80100);
    step();
    check("s2_rec_stop_low", 32'(bus.o_rec_stop), 32'd0);
    bus.i_key_stop = 1'b0;

    bus.i_slot_sel = 2'd1;
    bus.i_key_play = 1'b1;
    step();
    check("inv_play_no_start", 32'(bus.o_dsp_start), 32'd0);
    check("inv_play_state", 32'(bus.o_state), 32'd0);
    check("inv_play_active", 32'(bus.o_active_slot), 32'd2);
    bus.i_key_play = 1'b0;
    step();
    bus.i_slot_sel = 2'd2;
    bus.i_key_play = 1'b1;
    step();
    check("play_start", 32'(bus.o_dsp_start), 32'd1);
    check("play_state", 32'(bus.o_state), 32'd4);
    step();
    check("play_start_low", 32'(bus.o_dsp_start), 32'd0);
    bus.i_key_play = 1'b0;
    step();
    bus.i_key_play = 1'b1;
    step();
    check("play_pause", 32'(bus.o_dsp_pause), 32'd1);
    check("play_pause_state", 32'(bus.o_state), 32'd5);
    bus.i_key_play = 1'b0;
    step();
    bus.i_key_play = 1'b1;
    step();
    check("play_resume", 32'(bus.o_dsp_start), 32'd1);
    check("play_resume_state", 32'(bus.o_state), 32'd4);
    bus.i_key_play = 1'b0;
    bus.i_slot_sel = 2'd0;
    step();
    check("play_slot_frozen", 32'(bus.o_active_slot), 32'd2);

    bus.i_play_fin = 1'b1;
    step();
    check("fin_dsp_stop", 32'(bus.o_dsp_stop), 32'd1);
    bus.i_play_fin = 1'b0;
`ifdef REC_PLAY_LOOP_EN
    check("fin_loop_state", 32'(bus.o_state), 32'd4);
    step();
    check("fin_loop_restart", 32'(bus.o_dsp_start), 32'd1);
    check("fin_loop_stop_low", 32'(bus.o_dsp_stop), 32'd0);
    check("fin_loop_state2", 32'(bus.o_state), 32'd4);
    step();
    bus.i_key_stop = 1'b1;
    step();
    check("loop_exit_stop", 32'(bus.o_dsp_stop), 32'd1);
    check("loop_exit_state", 32'(bus.o_state), 32'd0);
    bus.i_key_stop = 1'b0;
`else
    check("fin_idle_state", 32'(bus.o_state), 32'd0);
    step();
    check("fin_no_restart", 32'(bus.o_dsp_start), 32'd0);
    check("fin_stop_low", 32'(bus.o_dsp_stop), 32'd0);
`endif
    step();

    bus.i_slot_sel = 2'd0;
    bus.i_rec_addr = 20'h00000;
    bus.i_key_rec  = 1'b1;
    step();
    check("s0_state_recd", 32'(bus.o_state), 32'd2);
    check("s0_base", 32'(bus.o_base_addr), 32'h0);
    bus.i_key_rec  = 1'b0;
    bus.i_rec_addr = 20'h01000;
    step();
    check("s0_no_early_stop", 32'(bus.o_rec_stop), 32'd0);
    bus.i_rec_addr = 20'h3FFFF;
    step();
    check("s0_auto_stop", 32'(bus.o_rec_stop), 32'd1);
    check("s0_auto_state", 32'(bus.o_state), 32'd0);
    check("s0_valid", 32'(bus.o_slot_valid), 32'b0101);
    check("s0_stop_addr", 32'(bus.o_stop_addr), 32'h3FFFF);
    step();

    bus.i_slot_sel = 2'd3;
    bus.i_rec_addr = 20'hC0000;
    bus.i_key_rec  = 1'b1;
    step();
    bus.i_key_rec = 1'b0;
    step();
    bus.i_key_rec = 1'b1;
    step();
    check("s3_rec_pause", 32'(bus.o_rec_pause), 32'd1);
    check("s3_pause_state", 32'(bus.o_state), 32'd3);
    bus.i_key_rec  = 1'b0;
    bus.i_rec_addr = 20'hC0010;
    step();
    check("s3_pause_we_n", 32'(bus.o_sram_we_n), 32'd1);
    bus.i_key_stop = 1'b1;
    step();
    check("s3_rec_stop", 32'(bus.o_rec_stop), 32'd1);
    check("s3_valid", 32'(bus.o_slot_valid), 32'b1101);
    check("s3_stop_addr", 32'(bus.o_stop_addr), 32'hC0010);
    bus.i_key_stop = 1'b0;
    step();

    bus.i_slot_sel = 2'd1;
    bus.i_rec_addr = 20'h40000;
    bus.i_key_rec  = 1'b1;
    step();
    bus.i_key_rec = 1'b0;
    step();
    bus.i_key_rec  = 1'b1;
    bus.i_key_stop = 1'b1;
    step();
    check("prio_rec_stop", 32'(bus.o_rec_stop), 32'd1);
    check("prio_no_pause", 32'(bus.o_rec_pause), 32'd0);
    check("prio_state", 32'(bus.o_state), 32'd0);
    check("zero_len_valid", 32'(bus.o_slot_valid), 32'b1101);
    bus.i_key_rec  = 1'b0;
    bus.i_key_stop = 1'b0;
    step();
    bus.i_key_stop = 1'b1;
    step();
    check("idle_stop_valid", 32'(bus.o_slot_valid), 32'b1101);
    check("idle_stop_state", 32'(bus.o_state), 32'd0);
    check("idle_stop_no_pulse", 32'(bus.o_rec_stop), 32'd0);
    bus.i_key_stop = 1'b0;
    step();

    bus.i_slot_sel = 2'd2;
    bus.i_rec_addr = 20'h80000;
    bus.i_key_rec  = 1'b1;
    step();
    check("rerec_clears_valid", 32'(bus.o_slot_valid), 32'b1001);
    bus.i_key_rec  = 1'b0;
    bus.i_rec_addr = 20'h80040;
    step();
    rst = 1'b1;
    #1;
    check("midrec_rst_state", 32'(bus.o_state), 32'd1);
    check("midrec_rst_valid", 32'(bus.o_slot_valid), 32'd0);
    check("midrec_rst_stop_addr", 32'(bus.o_stop_addr), 32'd0);
    check("midrec_rst_active", 32'(bus.o_active_slot), 32'd0);
    step();
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rec_play_ctrl.md
# rec_play_ctrl

Multi-slot record/playback controller for the audio recorder datapath. It sequences I2C codec init, then arbitrates record, pause, stop and play commands from debounced keys. It partitions SRAM into `SLOTS` equal regions and keeps a per-slot end address and valid flag. It drives single-cycle command pulses to the recorder and the DSP, plus the SRAM address mux select, and sits between the board keys and the recorder, DSP and player blocks.

## Interface
Parameters:
- `ADDR_W`, 20, SRAM word-address width.
- `SLOTS`, 4, number of recording slots; power of two, ≥2. `SLOT_W = $clog2(SLOTS)`, `SLOT_DEPTH = 2**ADDR_W / SLOTS` (both derived localparams).

Ports:
- `i_clk`  in  1  system clock
- `i_rst`  in  1  asynchronous, active-high reset
- `i_key_rec`, `i_key_play`, `i_key_stop`  in  1  debounced key levels; rising edges are commands
- `i_slot_sel`  in  SLOT_W  slot chosen by user
- `i_i2c_fin`  in  1  codec init done
- `i_rec_addr`  in  ADDR_W  recorder's current write address
- `i_rec_fin`, `i_play_fin`  in  1  recorder full / DSP reached stop address
- `o_i2c_start`  out  1  held high while in S_I2C
- `o_rec_start`, `o_rec_pause`, `o_rec_stop`, `o_dsp_start`, `o_dsp_pause`, `o_dsp_stop`  out  1  one-cycle command pulses
- `o_base_addr`  out  ADDR_W  `active_slot*SLOT_DEPTH`
- `o_stop_addr`  out  ADDR_W  stored end address of active slot
- `o_active_slot`  out  SLOT_W  latched slot
- `o_slot_valid`  out  SLOTS  per-slot "contains recording" mask
- `o_rec_sel`  out  1  1 in S_RECD (SRAM address/data from recorder)
- `o_sram_we_n`  out  1  `~o_rec_sel`
- `o_state`  out  3  current state encoding

## Operation
- States: S_IDLE=0, S_I2C=1, S_RECD=2, S_RECD_PAUSE=3, S_PLAY=4, S_PLAY_PAUSE=5. Unused encodings go to S_IDLE.
- Edge detect: `rise_x = i_key_x & ~key_x_d`. `key_x_d` is registered every cycle in every state.
- Same-cycle priority: stop > rec > play.
- S_I2C: keys ignored. On `i_i2c_fin`, go to S_IDLE.
- S_IDLE:
  - rise_rec: latch `active_slot=i_slot_sel`, clear `slot_valid[i_slot_sel]`, pulse rec_start, go to S_RECD.
  - rise_play: if `slot_valid[i_slot_sel]`, latch slot, pulse dsp_start, go to S_PLAY. Otherwise ignore.
- S_RECD:
  - rise_stop, `i_rec_fin`, or `i_rec_addr == base+SLOT_DEPTH-1`: store `end[active]=i_rec_addr`, pulse rec_stop, go to S_IDLE.
  - rise_rec: pulse rec_pause, go to S_RECD_PAUSE.
- S_RECD_PAUSE:
  - rise_stop: store end address as in S_RECD, pulse rec_stop, go to S_IDLE.
  - rise_rec: pulse rec_start, go to S_RECD.
- Valid rule on store: `slot_valid[active]` is set only if `i_rec_addr != o_base_addr`. A zero-length take leaves the slot invalid.
- S_PLAY:
  - rise_stop: pulse dsp_stop, go to S_IDLE.
  - `i_play_fin`: behaviour depends on the macro (see Configuration).
  - rise_play: pulse dsp_pause, go to S_PLAY_PAUSE.
- S_PLAY_PAUSE:
  - rise_stop: pulse dsp_stop, go to S_IDLE.
  - rise_play: pulse dsp_start, go to S_PLAY.
- `i_slot_sel` changes outside S_IDLE are ignored. The active slot is frozen until the next S_IDLE command.

## Timing
- All outputs are registered. A key first sampled high at edge n changes state and raises a pulse after edge n; the pulse is low again after edge n+1.
- Consecutive pulses on the same output require a new key rise; a held key produces exactly one pulse.
- Reset values:
  - state = S_I2C, `o_i2c_start` = 1.
  - all pulses = 0.
  - `o_slot_valid` = 0, end addresses = 0, `o_active_slot` = 0.
  - `o_rec_sel` = 0, `o_sram_we_n` = 1.
- Reset asserted mid-record drops the take: no end address is stored and valid stays 0.

## Configuration
- `REC_PLAY_LOOP_EN` defined: in S_PLAY, `i_play_fin` pulses dsp_stop, then dsp_start on the next cycle. The state remains S_PLAY (looped playback of the slot).
- `REC_PLAY_LOOP_EN` undefined: `i_play_fin` pulses dsp_stop and the state goes to S_IDLE.

## Test plan
- Reset, hold `i_i2c_fin=0` for 10 cycles, then 1 → `o_i2c_start=1` throughout, state 1→0 one cycle after fin. Keys during S_I2C give no pulses.
- `i_slot_sel=2`, rise_rec, drive `i_rec_addr` to 0x80100, rise_stop → rec_start and rec_stop one cycle each. `o_slot_valid=4'b0100`, `o_stop_addr=0x80100`, `o_base_addr=0x80000`.
- `i_slot_sel=1` (invalid slot), rise_play → no dsp_start, state stays 0. Switch to slot 2, rise_play → dsp_start, state 4.
- Recording in slot 0 with `i_rec_addr` reaching 0x3FFFF → auto rec_stop, valid[0]=1, state 0.
- rise_stop and rise_rec in the same cycle while in S_RECD → stop wins. Rise_stop in S_IDLE after zero-length take → valid stays 0.
- With and without `REC_PLAY_LOOP_EN`: `i_play_fin` in S_PLAY → with: dsp_stop then dsp_start, state 4. Without: dsp_stop, state 0.
